// File: rtl/coord_project_ctrl.sv
// Pinhole projection sequencer: one (x,y,z) point in, one clamped overlay pixel out.
// Both axes share a single restoring divider, run back to back.
module coord_project_ctrl #(
   parameter int unsigned FX       = 437,
   parameter int unsigned FY       = 330,
   parameter int unsigned CX       = 242,
   parameter int unsigned CY       = 145,
   parameter int unsigned SCALE_Q8 = 337,
   parameter int unsigned IMG_W    = 640,
   parameter int unsigned IMG_H    = 480
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [31:0] in_x,
   input  logic signed [31:0] in_y,
   input  logic signed [15:0] in_z,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [15:0]        out_u,
   output logic [15:0]        out_v,
   output logic               out_clip,
   output logic               out_err,
   output logic               busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_MUL, S_DIV_X, S_DIV_Y, S_SCALE, S_OUT, S_ERR
   } state_t;

   localparam logic signed [47:0] FX_S  = 48'(FX);
   localparam logic signed [47:0] FY_S  = 48'(FY);
   localparam logic signed [47:0] CX_S  = 48'(CX);
   localparam logic signed [47:0] CY_S  = 48'(CY);
   localparam logic [15:0]        U_MAX = 16'(IMG_W - 1);
   localparam logic [15:0]        V_MAX = 16'(IMG_H - 1);

   state_t state_q, state_d;

   logic signed [31:0] x_q, y_q;
   logic signed [15:0] z_q;
   logic signed [47:0] numy_q;
   logic               neg_q;
   logic [47:0]        dvd_q;
   logic [15:0]        rem_q;
   logic [5:0]         cnt_q;
   logic signed [47:0] qx_q, qy_q;
   logic [15:0]        out_u_q, out_v_q;
   logic               out_clip_q, out_err_q;

   function automatic logic [47:0] abs48(input logic signed [47:0] a);
      return a[47] ? -a : a;
   endfunction

   // Returns {clip, pixel}; negative quotients clamp to 0, large ones to lim.
   function automatic logic [16:0] scale_axis(input logic signed [47:0] q,
                                             input logic [15:0] lim);
      logic [57:0] prod;
      logic [49:0] pix;
      prod = 58'(q[46:0]) * 58'(SCALE_Q8);
      pix  = 50'(prod >> 8);
      if (q[47])
         return {1'b1, 16'd0};
      if (pix > 50'(lim))
         return {1'b1, lim};
      return {1'b0, pix[15:0]};
   endfunction

   logic signed [47:0] x_ext, y_ext, z_ext;
   logic signed [47:0] num_x_c, num_y_c;
   logic [16:0]        rem_sh;
   logic               div_ge;
   logic [47:0]        dvd_nx;
   logic signed [47:0] quot_c;
   logic               div_last;
   logic [16:0]        u_res, v_res;

   assign x_ext    = {{16{x_q[31]}}, x_q};
   assign y_ext    = {{16{y_q[31]}}, y_q};
   assign z_ext    = {{32{z_q[15]}}, z_q};
   assign num_x_c  = FX_S * x_ext + CX_S * z_ext;
   assign num_y_c  = FY_S * y_ext + CY_S * z_ext;

   assign rem_sh   = {rem_q, dvd_q[47]};
   assign div_ge   = rem_sh >= {1'b0, z_q};
   assign dvd_nx   = {dvd_q[46:0], div_ge};
   assign quot_c   = neg_q ? -$signed(dvd_nx) : $signed(dvd_nx);
   assign div_last = (cnt_q == 6'd47);

   assign u_res    = scale_axis(qx_q, U_MAX);
   assign v_res    = scale_axis(qy_q, V_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid) state_d = (in_z <= 16'sd0) ? S_ERR : S_MUL;
         S_MUL:   state_d = S_DIV_X;
         S_DIV_X: if (div_last) state_d = S_DIV_Y;
         S_DIV_Y: if (div_last) state_d = S_SCALE;
         S_SCALE: state_d = S_OUT;
         S_ERR:   state_d = S_OUT;
         S_OUT:   if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = rst_n && (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
      out_valid = (state_q == S_OUT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q        <= '0;
         y_q        <= '0;
         z_q        <= '0;
         numy_q     <= '0;
         neg_q      <= 1'b0;
         dvd_q      <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         qx_q       <= '0;
         qy_q       <= '0;
         out_u_q    <= '0;
         out_v_q    <= '0;
         out_clip_q <= 1'b0;
         out_err_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  x_q <= in_x;
                  y_q <= in_y;
                  z_q <= in_z;
               end
            end
            S_MUL: begin
               numy_q <= num_y_c;
               neg_q  <= num_x_c[47];
               dvd_q  <= abs48(num_x_c);
               rem_q  <= '0;
               cnt_q  <= '0;
            end
            S_DIV_X, S_DIV_Y: begin
               rem_q <= div_ge ? 16'(rem_sh - {1'b0, z_q}) : rem_sh[15:0];
               dvd_q <= dvd_nx;
               cnt_q <= cnt_q + 6'd1;
               if (div_last) begin
                  rem_q <= '0;
                  cnt_q <= '0;
                  if (state_q == S_DIV_X) begin
                     // Reload the shared divider with the y numerator.
                     qx_q  <= quot_c;
                     neg_q <= numy_q[47];
                     dvd_q <= abs48(numy_q);
                  end else begin
                     qy_q <= quot_c;
                  end
               end
            end
            S_SCALE: begin
               out_u_q    <= u_res[15:0];
               out_v_q    <= v_res[15:0];
               out_clip_q <= u_res[16] | v_res[16];
               out_err_q  <= 1'b0;
            end
            S_ERR: begin
               out_u_q    <= '0;
               out_v_q    <= '0;
               out_clip_q <= 1'b0;
               out_err_q  <= 1'b1;
            end
            S_OUT: begin
               if (out_ready) begin
                  out_clip_q <= 1'b0;
                  out_err_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_u    = out_u_q;
   assign out_v    = out_v_q;
   assign out_clip = out_clip_q;
   assign out_err  = out_err_q;

endmodule

// File: tb/tb_coord_project_ctrl.sv
// Scoreboard bench for coord_project_ctrl: a behavioural projection model predicts
// each pixel pair and latency; results are popped and compared as they appear.
module tb_coord_project_ctrl;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               out_ready = 1'b0;
   logic signed [31:0] in_x = '0;
   logic signed [31:0] in_y = '0;
   logic signed [15:0] in_z = '0;
   logic               in_ready, out_valid, out_clip, out_err, busy;
   logic [15:0]        out_u, out_v;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int t_acc = 0;

   typedef struct {
      int u;
      int v;
      bit clip;
      bit err;
      int lat;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   coord_project_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_z      (in_z),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_u     (out_u),
      .out_v     (out_v),
      .out_clip  (out_clip),
      .out_err   (out_err),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic void proj_axis(input longint q, input longint lim,
                                     output int p, output bit c);
      longint s;
      c = 1'b0;
      if (q < 0) begin
         p = 0;
         c = 1'b1;
      end else begin
         s = (q * 337) / 256;
         if (s > lim) begin
            s = lim;
            c = 1'b1;
         end
         p = int'(s);
      end
   endfunction

   function automatic exp_t model(input int x, input int y, input int z);
      exp_t   e;
      longint nx, ny;
      bit     cu, cv;
      e = '{default: 0};
      if (z <= 0) begin
         e.err = 1'b1;
         e.lat = 2;
         return e;
      end
      nx = longint'(x) * 437 + longint'(z) * 242;
      ny = longint'(y) * 330 + longint'(z) * 145;
      proj_axis(nx / longint'(z), 639, e.u, cu);
      proj_axis(ny / longint'(z), 479, e.v, cv);
      e.clip = cu | cv;
      e.lat  = 99;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_point(input int x, input int y, input int z);
      bit ok = 1'b0;
      sb_q.push_back(model(x, y, z));
      in_x = x;
      in_y = y;
      in_z = 16'(z);
      in_valid = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         ok = in_ready;
         step();
      end
      if (!ok) check("accept_timeout", 0, 1);
      t_acc = cyc;
      in_valid = 1'b0;
      in_x = $urandom;
      in_y = $urandom;
      in_z = 16'($urandom);
      $display("sent x=%0d y=%0d z=%0d accepted at cycle %0d", x, y, z, t_acc);
   endtask

   task automatic recv(input int stall);
      bit   seen = 1'b0;
      exp_t e;
      for (int i = 0; i < 300 && !seen; i++) begin
         if (out_valid) seen = 1'b1;
         else step();
      end
      if (!seen) begin
         check("out_timeout", 0, 1);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
         return;
      end
      if (sb_q.size() == 0) begin
         check("unexpected_output", 0, 1);
         return;
      end
      e = sb_q.pop_front();
      check("latency", cyc - t_acc + 1, e.lat);
      check("u", out_u, e.u);
      check("v", out_v, e.v);
      check("clip", out_clip, e.clip);
      check("err", out_err, e.err);
      $display("result u=%0d v=%0d clip=%0d err=%0d latency=%0d (exp u=%0d v=%0d clip=%0d err=%0d)",
               out_u, out_v, out_clip, out_err, cyc - t_acc + 1, e.u, e.v, e.clip, e.err);
      for (int i = 0; i < stall; i++) begin
         step();
         check("stall_valid", out_valid, 1);
         check("stall_u", out_u, e.u);
         check("stall_v", out_v, e.v);
         check("stall_in_ready", in_ready, 0);
         check("stall_busy", busy, 1);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("pop_valid", out_valid, 0);
      check("pop_busy", busy, 0);
      check("pop_in_ready", in_ready, 1);
   endtask

   initial begin
      step();
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_u", out_u, 0);
      check("rst_v", out_v, 0);
      check("rst_clip", out_clip, 0);
      check("rst_err", out_err, 0);
      rst_n = 1'b1;
      step();
      check("rst_in_ready", in_ready, 1);

      send_point(0, 0, 100);        recv(0);
      send_point(-100, -50, 1000);  recv(0);
      send_point(-1000, 0, 100);    recv(0);
      send_point(100, 50, 10);      recv(0);
      send_point(-554, 0, 1000);    recv(0);
      send_point(0, 0, 0);          recv(3);
      send_point(3, 4, -5);         recv(3);
      send_point(0, 0, 100);        recv(20);
      send_point(0, 0, 100);        recv(0);

      for (int k = 0; k < 4; k++) begin
         send_point(int'($urandom_range(0, 4000)) - 2000,
                    int'($urandom_range(0, 4000)) - 2000,
                    int'($urandom_range(1, 3000)));
         recv(k);
      end

      // Abort a point mid-divide and confirm the next one is unaffected.
      send_point(-300, 77, 250);
      repeat (59) step();
      rst_n = 1'b0;
      #1;
      check("abort_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      void'(sb_q.pop_front());
      step();
      step();
      rst_n = 1'b1;
      #2;
      check("abort_in_ready", in_ready, 1);
      step();
      send_point(0, 0, 100);
      recv(0);

      check("queue_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
